// File: rtl/imem_boot_loader.sv
// Instruction memory boot loader: packs a length-prefixed big-endian byte
// stream into 32-bit words and writes them while holding the CPU in reset.
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr,
  output logic [31:0] write_address,
  output logic [31:0] instruc_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] words_written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic [31:0] r_len;
  logic [31:0] r_index;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_words;
  logic        r_hold;

  logic        w_xfer;
  logic        w_last;
  logic        w_armable;
  logic        w_start_ok;
  logic [31:0] w_shift;
  logic [31:0] w_idx_nxt;

  assign w_xfer     = in_valid & in_ready;
  assign w_last     = w_xfer & (r_cnt == 2'd3);
  assign w_shift    = {r_word[23:0], in_data};
  assign w_idx_nxt  = r_index + 32'd1;
  assign w_armable  = (r_state == S_IDLE) | (r_state == S_DONE)
                    | (r_state == S_ERR);
  assign w_start_ok = start & w_armable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_last) begin
          if (w_shift == 32'd0)                 w_next = S_DONE;
          else if (w_shift > 32'(MEM_WORDS))    w_next = S_ERR;
          else                                  w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = (w_idx_nxt == r_len) ? S_DONE : S_DATA;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= 2'd0;
      r_word  <= 32'd0;
      r_len   <= 32'd0;
      r_index <= 32'd0;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
      r_words <= 32'd0;
      r_hold  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_hold  <= 1'b1;
        r_words <= 32'd0;
        r_cnt   <= 2'd0;
      end
      if (w_xfer) begin
        r_cnt  <= r_cnt + 2'd1;
        r_word <= w_shift;
      end
      if ((r_state == S_LEN) && w_last) begin
        r_len   <= w_shift;
        r_index <= 32'd0;
      end
      // address/data latched with the 4th byte so WRITE drives them directly
      if ((r_state == S_DATA) && w_last) begin
        r_addr <= BASE_ADDR + (r_index << 2);
        r_data <= w_shift;
      end
      if (r_state == S_WRITE) begin
        r_index <= w_idx_nxt;
        r_words <= r_words + 32'd1;
      end
      if (w_next == S_DONE) r_hold <= 1'b0;
    end
  end

  assign in_ready      = (r_state == S_LEN) | (r_state == S_DATA);
  assign wr            = (r_state == S_WRITE);
  assign busy          = in_ready | wr;
  assign done          = (r_state == S_DONE);
  assign error         = (r_state == S_ERR);
  assign cpu_hold      = r_hold;
  assign write_address = r_addr;
  assign instruc_data  = r_data;
  assign words_written = r_words;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Upstream feeder for the instruction memory's write port. It takes a byte stream (header plus program words) from a host or UART front end, packs the bytes into 32-bit big-endian instructions, and drives the memory's write strobe, write address and write data. While loading it holds the CPU in reset. It releases the CPU once the last word is written.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first instruction written; must be word-aligned.
MEM_WORDS, 8192, capacity of the instruction memory in 32-bit words; longer programs are rejected.

Ports:
clock  input  1  single system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; arms a load from IDLE or DONE/ERR; ignored otherwise.
in_data  input  8  stream byte.
in_valid  input  1  in_data valid this cycle.
in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready at the rising edge.
wr  output  1  instruction memory write enable, exactly one cycle per word.
write_address  output  32  byte address for the write: BASE_ADDR + 4*index.
instruc_data  output  32  instruction word to write.
cpu_hold  output  1  keeps the processor in reset while loading.
busy  output  1  high in LEN, DATA and WRITE.
done  output  1  high in DONE.
error  output  1  high in ERR.
words_written  output  32  count of words written in the current or last load.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - wr=0, write_address=0, instruc_data=0, in_ready=0, busy=0, done=0, error=0, cpu_hold=0, words_written=0.
  - Byte counter and length register are cleared.
  - Reset mid-load abandons the load. Words already written stay in memory.
- All outputs are registered or decoded from state; no combinational path from in_valid to in_ready.
- States:
  - IDLE: in_ready=0. start goes to LEN; cpu_hold is set to 1 and words_written is cleared on the same edge.
  - LEN: in_ready=1. Accept 4 bytes; the first byte is the MSB, giving length N. On the edge that accepts the 4th byte:
    - N==0: go to DONE.
    - N>MEM_WORDS: go to ERR.
    - Otherwise: go to DATA, with index=0.
  - DATA: in_ready=1. Accept 4 bytes, MSB first, shifting each into the word register. The 4th byte goes to WRITE.
  - WRITE: exactly one cycle, with in_ready=0.
    - wr=1, instruc_data=assembled word, write_address=BASE_ADDR+(index<<2).
    - On exit: index+1 and words_written+1.
    - Go to DONE if the new index equals N, otherwise back to DATA.
  - DONE: done=1, cpu_hold=0, busy=0, in_ready=0. start goes to LEN (done clears, cpu_hold=1).
  - ERR: error=1, cpu_hold stays 1, in_ready=0, no writes. Only start (goes to LEN, error clears) or reset leaves ERR.
- Latency:
  - wr is asserted in the cycle immediately after the edge that accepted a word's 4th byte.
  - Minimum 5 cycles per word with in_valid held high.
- Gaps in in_valid stall byte assembly indefinitely; a partial word is kept.
- start while busy is ignored.
- in_valid in IDLE, DONE or ERR: the byte is not consumed.
- Address arithmetic is 32-bit modulo. wr is never asserted outside WRITE.

Test Plan:
- Normal load: start; bytes 00 00 00 02, 20 08 00 05, AC 08 00 04 with in_valid continuous.
  - wr pulses twice: (addr 0x0, data 0x20080005), then (addr 0x4, data 0xAC080004).
  - Each wr comes one cycle after the 4th byte of its word.
  - Then done=1, cpu_hold=0, words_written=2.
- Zero length: start; 00 00 00 00.
  - Next state DONE, no wr pulse, words_written=0, cpu_hold 1 then 0.
- Overflow: start; length 00 00 20 01 (8193).
  - error=1, cpu_hold=1, no wr, in_ready=0.
  - A following start returns to LEN with error=0.
- Backpressure: 1-word load with 3 idle cycles of in_valid=0 inserted between data bytes.
  - The word still assembles correctly: a single wr with the correct data, in_ready=0 during WRITE.
- Reset mid-load: 3-word load, assert reset after the first wr.
  - All outputs are 0 immediately.
  - A fresh start and load from index 0 writes to address BASE_ADDR again.
- Restart and ignore: start pulsed during DATA has no effect.
  - After DONE, a second start with 1 word writes address 0x0 again; words_written reads 1.
